// File: rtl/interp_pkg.sv
// Shared types and constants for the polyphase FIR interpolator.
// Contents: sample/coefficient types, widths, accumulator width helper,
// FSM state type and the default 16-tap halfband prototype filter.
package interp_pkg;

    localparam int unsigned SAMPLE_W      = 32;
    localparam int unsigned DEF_COEF_W    = 16;
    localparam int unsigned DEF_FRAC_BITS = 8;
    localparam int unsigned DEF_TAPS      = 16;

    typedef logic signed [SAMPLE_W-1:0]   sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;

    // Accumulator wide enough to sum tpp full-precision products without overflow.
    function automatic int unsigned acc_width(input int unsigned coef_w, input int unsigned tpp);
        return SAMPLE_W + coef_w + $clog2(tpp);
    endfunction

    localparam int unsigned ACC_W = acc_width(DEF_COEF_W, DEF_TAPS / 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } state_t;

    // Halfband, DC gain 2: odd phase is a pure delay (centre tap 1.0),
    // even phase is the interpolating half whose taps sum to 1.0.
    localparam coef_t DEFAULT_COEFS [DEF_TAPS] = '{
        -16'sd3,   16'sd0,  16'sd10,  16'sd0, -16'sd28,  16'sd0, 16'sd149, 16'sd256,
        16'sd149,  16'sd0, -16'sd28,  16'sd0,  16'sd10,  16'sd0, -16'sd3,  16'sd0
    };

endpackage

// File: rtl/interp_if.sv
// Sample stream interface of the interpolator.
// Ports: new_sample/valid_in (producer -> interpolator),
//        WAIT, interp_output, output_valid, overrun (interpolator -> system).
// master: producer side; slave: interpolator side.
interface interp_if;
    import interp_pkg::*;

    sample_t new_sample;
    logic    valid_in;
    logic    WAIT;
    sample_t interp_output;
    logic    output_valid;
    logic    overrun;

    modport master (
        output new_sample, valid_in,
        input  WAIT, interp_output, output_valid, overrun
    );

    modport slave (
        input  new_sample, valid_in,
        output WAIT, interp_output, output_valid, overrun
    );

endinterface

// File: rtl/interp_mac.sv
// Time-shared multiply-accumulate for the interpolator: signed product,
// accumulator with load/add, floor shift by FRAC_BITS and registered output.
// Ports: clk, rst (async active-low), en_i (MAC step), first_i (load instead
// of add), last_i (emit result), sample_i, coef_i, result_o, valid_o.
// Build option: INTERP_SAT_EN saturates the result to 32 bits, otherwise wraps.
module interp_mac
    import interp_pkg::*;
#(
    parameter int unsigned COEF_W    = DEF_COEF_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned TPP       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  sample_t                  sample_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output sample_t                  result_o,
    output logic                     valid_o
);

    localparam int unsigned PROD_W = SAMPLE_W + COEF_W;
    localparam int unsigned MAC_W  = acc_width(COEF_W, TPP);

    logic signed [PROD_W-1:0] prod_c;
    logic signed [MAC_W-1:0]  base_c;
    logic signed [MAC_W-1:0]  acc_d;
    logic signed [MAC_W-1:0]  acc_q;
    sample_t                  res_c;
    sample_t                  result_q;
    logic                     valid_q;

    // Full-precision signed product; both operands sign-extended first.
    assign prod_c = PROD_W'(sample_i) * PROD_W'(coef_i);
    assign base_c = first_i ? '0 : acc_q;
    assign acc_d  = base_c + MAC_W'(prod_c);

`ifdef INTERP_SAT_EN
    logic signed [MAC_W-1:0]      shifted_c;
    logic [MAC_W-SAMPLE_W:0]      top_c;

    assign shifted_c = acc_d >>> FRAC_BITS;
    assign top_c     = shifted_c[MAC_W-1:SAMPLE_W-1];

    // Clamp when the bits above the 32-bit sign position disagree.
    always_comb begin
        res_c = shifted_c[SAMPLE_W-1:0];
        if (top_c != '0 && top_c != '1) begin
            res_c = shifted_c[MAC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                       : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end
`else
    // Floor shift then keep the low 32 bits (two's-complement wrap).
    assign res_c = acc_d[FRAC_BITS +: SAMPLE_W];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (en_i) begin
                acc_q <= acc_d;
                if (last_i) begin
                    result_q <= res_c;
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign result_o = result_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/interpolator.sv
// Polyphase FIR interpolator: each accepted Q24.8 sample yields INTERP_FACTOR
// filtered Q24.8 outputs using one shared MAC, one product per cycle.
// Ports: clk, rst (async active-low), bus (interp_if.slave: new_sample,
// valid_in, WAIT, interp_output, output_valid, overrun).
// Build option: INTERP_SAT_EN (output saturation, see interp_mac).
module interpolator
    import interp_pkg::*;
#(
    parameter int unsigned              INTERP_FACTOR = 2,
    parameter int unsigned              TAP_SIZE      = DEF_TAPS,
    parameter int unsigned              COEF_W        = DEF_COEF_W,
    parameter int unsigned              FRAC_BITS     = DEF_FRAC_BITS,
    parameter logic signed [COEF_W-1:0] COEFS [TAP_SIZE] = DEFAULT_COEFS
) (
    input logic     clk,
    input logic     rst,
    interp_if.slave bus
);

    localparam int unsigned TPP   = TAP_SIZE / INTERP_FACTOR;
    localparam int unsigned K_W   = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int unsigned P_W   = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam int unsigned IDX_W = (TAP_SIZE > 1) ? $clog2(TAP_SIZE) : 1;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [P_W-1:0]     p_q, p_d;
    sample_t            x_q [TPP];
    sample_t            x_d [TPP];
    logic               wait_q;
    logic               overrun_q, overrun_d;

    logic               mac_en_c;
    logic               first_c;
    logic               last_c;
    logic [IDX_W-1:0]   idx_c;

    assign mac_en_c = (state_q == ST_MAC);
    assign first_c  = (k_q == '0);
    assign last_c   = (k_q == K_W'(TPP - 1));
    // Tap of phase p at delay k sits at h[k*L + p].
    assign idx_c    = IDX_W'(k_q) * IDX_W'(INTERP_FACTOR) + IDX_W'(p_q);

    // Next-state: acceptance/shift in IDLE, tap and phase sequencing in MAC.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        p_d       = p_q;
        x_d       = x_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    x_d[0] = bus.new_sample;
                    for (int i = 1; i < TPP; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    k_d     = '0;
                    p_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                // Busy: any offered sample is dropped and flagged.
                if (bus.valid_in) begin
                    overrun_d = 1'b1;
                end
                if (last_c) begin
                    k_d = '0;
                    if (p_q == P_W'(INTERP_FACTOR - 1)) begin
                        p_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            p_q       <= '0;
            wait_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < TPP; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            p_q       <= p_d;
            wait_q    <= (state_d != ST_IDLE);
            overrun_q <= overrun_d;
            x_q       <= x_d;
        end
    end

    interp_mac #(
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS),
        .TPP       (TPP)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en_i     (mac_en_c),
        .first_i  (first_c),
        .last_i   (last_c),
        .sample_i (x_q[k_q]),
        .coef_i   (COEFS[idx_c]),
        .result_o (bus.interp_output),
        .valid_o  (bus.output_valid)
    );

    assign bus.WAIT    = wait_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_interpolator.sv
// Scoreboard bench for the interpolator: two instances (default halfband and
// all-2.0 coefficients) share one input stream. A convolution model predicts
// each output and the WAIT/output_valid/overrun timeline; a monitor compares.
module tb_interpolator;

    localparam int L   = 2;
    localparam int TPP = 8;
    localparam logic signed [15:0] BIG_COEFS [16] = '{default: 16'sh0200};

    int coef_a [16] = '{-3, 0, 10, 0, -28, 0, 149, 256, 149, 0, -28, 0, 10, 0, -3, 0};
    int coef_b [16] = '{default: 512};

    logic clk = 1'b0;
    logic rst = 1'b0;

    interp_if bus_a ();
    interp_if bus_b ();

    assign bus_b.new_sample = bus_a.new_sample;
    assign bus_b.valid_in   = bus_a.valid_in;

    interpolator dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    interpolator #(
        .COEFS (BIG_COEFS)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          busy     = 0;
    bit          exp_ov   = 1'b0;
    bit          m_over   = 1'b0;
    longint      hist [$];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // y[L*n+p] = floor(sum_k h[k*L+p] * x[n-k] / 2^8), then wrap or clamp to 32 bits.
    function automatic logic [31:0] ref_out(input int h [16], input int p);
        longint acc;
        acc = 0;
        for (int k = 0; k < TPP; k++) begin
            if (k < hist.size()) acc += longint'(h[k*L+p]) * hist[k];
        end
        acc = acc >>> 8;
`ifdef INTERP_SAT_EN
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
        return acc[31:0];
    endfunction

    // Behavioural timing: a sample is taken when idle, then L*TPP busy cycles.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            busy   = 0;
            exp_ov = 1'b0;
            m_over = 1'b0;
            hist.delete();
            qa.delete();
            qb.delete();
        end else begin
            exp_ov = 1'b0;
            if (busy == 0) begin
                if (bus_a.valid_in) begin
                    hist.push_front(longint'($signed(bus_a.new_sample)));
                    if (hist.size() > TPP) void'(hist.pop_back());
                    for (int p = 0; p < L; p++) begin
                        qa.push_back(ref_out(coef_a, p));
                        qb.push_back(ref_out(coef_b, p));
                    end
                    busy = L * TPP;
                end
            end else begin
                if (bus_a.valid_in) m_over = 1'b1;
                busy--;
                exp_ov = (busy % TPP == 0);
            end
        end
    end

    // Monitor: status timeline every cycle, scoreboard pop on each output.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            last_a = '0;
            last_b = '0;
        end else begin
            chk("wait_a",    {31'b0, bus_a.WAIT},         {31'b0, busy != 0});
            chk("wait_b",    {31'b0, bus_b.WAIT},         {31'b0, busy != 0});
            chk("ovalid_a",  {31'b0, bus_a.output_valid}, {31'b0, exp_ov});
            chk("ovalid_b",  {31'b0, bus_b.output_valid}, {31'b0, exp_ov});
            chk("overrun_a", {31'b0, bus_a.overrun},      {31'b0, m_over});
            chk("overrun_b", {31'b0, bus_b.overrun},      {31'b0, m_over});
            if (bus_a.output_valid) begin
                if (qa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out_a unexpected got=%h required=none", bus_a.interp_output);
                end else begin
                    last_a = qa.pop_front();
                    chk("out_a", bus_a.interp_output, last_a);
                end
            end else begin
                chk("hold_a", bus_a.interp_output, last_a);
            end
            if (bus_b.output_valid) begin
                if (qb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out_b unexpected got=%h required=none", bus_b.interp_output);
                end else begin
                    last_b = qb.pop_front();
                    chk("out_b", bus_b.interp_output, last_b);
                end
            end else begin
                chk("hold_b", bus_b.interp_output, last_b);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wait_a"},    {31'b0, bus_a.WAIT},         32'd0);
        chk({tag, "_ovalid_a"},  {31'b0, bus_a.output_valid}, 32'd0);
        chk({tag, "_overrun_a"}, {31'b0, bus_a.overrun},      32'd0);
        chk({tag, "_out_a"},     bus_a.interp_output,         32'd0);
        chk({tag, "_wait_b"},    {31'b0, bus_b.WAIT},         32'd0);
        chk({tag, "_ovalid_b"},  {31'b0, bus_b.output_valid}, 32'd0);
        chk({tag, "_overrun_b"}, {31'b0, bus_b.overrun},      32'd0);
        chk({tag, "_out_b"},     bus_b.interp_output,         32'd0);
    endtask

    // Offer one sample as soon as the model says the DUT is idle.
    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        while (busy != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy != 0) begin
            checks++; failures++;
            $display("FAIL send_timeout busy=%0d required=0", busy);
        end
        bus_a.new_sample = d;
        bus_a.valid_in   = 1'b1;
        @(posedge clk); #1;
        bus_a.valid_in   = 1'b0;
    endtask

    initial begin
        int v;
        bus_a.new_sample = '0;
        bus_a.valid_in   = 1'b0;
        rst              = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        rst = 1'b1;

        // Impulse: outputs walk through the prototype taps.
        send(32'h0000_0100);
        repeat (7) send(32'h0);

        // DC: even/odd phase sums.
        repeat (8) send(32'h0000_0100);

        // Full-scale extremes drive the large-coefficient instance out of range.
        repeat (8) send(32'h7FFF_FFFF);
        repeat (8) send(32'h8000_0000);

        // Valid held high: only every L*TPP+1 cycle accepts, overrun latches.
        for (int i = 0; i < 80; i++) begin
            bus_a.new_sample = $urandom;
            bus_a.valid_in   = 1'b1;
            @(posedge clk); #1;
        end
        bus_a.valid_in = 1'b0;

        // Random samples with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            if (i % 2 == 0) v = int'($urandom_range(0, 8191)) - 4096;
            else            v = int'($urandom);
            send(v);
        end

        // Reset in the middle of a MAC run.
        send(32'h0000_4000);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Impulse again: no residue from the aborted sample.
        send(32'h0000_0100);
        repeat (7) send(32'h0);

        repeat (40) @(posedge clk);
        #1;
        chk("drain_a", qa.size(), 32'd0);
        chk("drain_b", qb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
